// File: rtl/mem_access_ctrl_if.sv
// Bundles the CPU request/response handshake and the word-wide data-memory
// bus of mem_access_ctrl. "slave" is the controller's view, "master" is the
// view of the CPU and memory side that surrounds it.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_done;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_exc;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_done, rsp_data, rsp_exc, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_done, rsp_data, rsp_exc, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one CPU data-memory load/store per request.
// Loads read the word and return the addressed lane(s) right-justified;
// sub-word stores do a read-modify-write; misaligned or invalid-size
// requests complete without touching memory and report an exception code.
// Optional feature: define SIGN_EXT_EN to sign-extend byte/half loads that
// carry req_signed=1 (otherwise all loads zero-extend).
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RD    | mem_rd held for MEM_LAT cycles, data captured on the last one
// WR    | single-cycle mem_wr with the (merged) word
// DONE  | rsp_done pulse with rsp_data / rsp_exc
module mem_access_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input logic           clk,
  input logic           reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lo_q, lo_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rsp_done_q, rsp_done_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_exc_q, rsp_exc_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        sext;
  logic [1:0]  exc_in;

`ifdef SIGN_EXT_EN
  logic        signed_q, signed_d;
  assign sext = signed_q;
`else
  logic        unused_signed;
  assign unused_signed = bus.req_signed;
  assign sext = 1'b0;
`endif

  function automatic logic [1:0] fault_code(input logic wr, input logic [1:0] sz,
                                            input logic [1:0] lo);
    logic [1:0] code;
    code = 2'b00;
    if (sz == 2'b11) code = 2'b11;
    else if ((sz == 2'b01 && lo[0]) || (sz == 2'b10 && lo != 2'b00))
      code = wr ? 2'b10 : 2'b01;
    return code;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] lo, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Sub-word store: replace only the addressed lane(s) of the old word.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                        input logic [1:0] lo, input logic [15:0] wd);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) r[{lo, 3'b000} +: 8] = wd[7:0];
    else             r[{lo[1], 4'b0000} +: 16] = wd;
    return r;
  endfunction

  assign exc_in = fault_code(bus.req_write, bus.req_size, bus.req_addr[1:0]);

  // Next state plus registered outputs for the cycle that follows.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    lo_d        = lo_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_done_d  = 1'b0;
    rsp_data_d  = 32'h0;
    rsp_exc_d   = 2'b00;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    mem_addr_d  = mem_addr_q;
`ifdef SIGN_EXT_EN
    signed_d    = signed_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d    = bus.req_write;
          size_d     = bus.req_size;
          lo_d       = bus.req_addr[1:0];
          wdata_d    = bus.req_wdata[15:0];
          mem_addr_d = {bus.req_addr[31:2], 2'b00};
`ifdef SIGN_EXT_EN
          signed_d   = bus.req_signed;
`endif
          if (exc_in != 2'b00) begin
            state_d    = DONE;
            rsp_done_d = 1'b1;
            rsp_exc_d  = exc_in;
          end else if (bus.req_write && bus.req_size == 2'b10) begin
            state_d     = WR;
            mem_wr_d    = 1'b1;
            mem_wdata_d = bus.req_wdata;
          end else begin
            state_d  = RD;
            mem_rd_d = 1'b1;
            cnt_d    = LAT_M1;
          end
        end
      end
      RD: begin
        if (cnt_q != 2'd0) begin
          cnt_d    = cnt_q - 2'd1;
          mem_rd_d = 1'b1;
        end else if (write_q) begin
          state_d     = WR;
          mem_wr_d    = 1'b1;
          mem_wdata_d = merge(bus.mem_rdata, size_q, lo_q, wdata_q);
        end else begin
          state_d    = DONE;
          rsp_done_d = 1'b1;
          rsp_data_d = load_ext(bus.mem_rdata, size_q, lo_q, sext);
        end
      end
      WR: begin
        state_d    = DONE;
        rsp_done_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered outputs; reset drops any request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      lo_q        <= 2'b00;
      wdata_q     <= 16'h0;
      cnt_q       <= 2'd0;
      rsp_done_q  <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_exc_q   <= 2'b00;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 32'h0;
      mem_addr_q  <= 32'h0;
`ifdef SIGN_EXT_EN
      signed_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      lo_q        <= lo_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_done_q  <= rsp_done_d;
      rsp_data_q  <= rsp_data_d;
      rsp_exc_q   <= rsp_exc_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_addr_q  <= mem_addr_d;
`ifdef SIGN_EXT_EN
      signed_q    <= signed_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE) && reset;
  assign bus.rsp_done  = rsp_done_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_exc   = rsp_exc_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: two instances (MEM_LAT=1 and 3) see the
// same requests, each with its own small word memory.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  mem_access_ctrl_if bus1();
  mem_access_ctrl_if bus3();

  assign bus1.req_valid  = req_valid;
  assign bus1.req_write  = req_write;
  assign bus1.req_size   = req_size;
  assign bus1.req_signed = req_signed;
  assign bus1.req_addr   = req_addr;
  assign bus1.req_wdata  = req_wdata;
  assign bus3.req_valid  = req_valid;
  assign bus3.req_write  = req_write;
  assign bus3.req_size   = req_size;
  assign bus3.req_signed = req_signed;
  assign bus3.req_addr   = req_addr;
  assign bus3.req_wdata  = req_wdata;

  logic [31:0] mem1 [0:15];
  logic [31:0] mem3 [0:15];
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;

  assign bus1.mem_rdata = mem1[bus1.mem_addr[5:2]];
  assign bus3.mem_rdata = mem3[bus3.mem_addr[5:2]];

  always @(posedge clk) begin
    if (pre_en) begin
      mem1[pre_idx] <= pre_val;
      mem3[pre_idx] <= pre_val;
    end
    if (bus1.mem_wr) mem1[bus1.mem_addr[5:2]] <= bus1.mem_wdata;
    if (bus3.mem_wr) mem3[bus3.mem_addr[5:2]] <= bus3.mem_wdata;
  end

  mem_access_ctrl #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  mem_access_ctrl #(.MEM_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

`ifdef SIGN_EXT_EN
  localparam logic SE = 1'b1;
`else
  localparam logic SE = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  int          done_cyc [2];
  int          done_cnt [2];
  int          rd_cnt   [2];
  int          wr_cnt   [2];
  int          first_rd [2];
  logic [31:0] rdata    [2];
  logic [1:0]  rexc     [2];
  logic [31:0] wdata    [2];
  logic [31:0] waddr    [2];

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      done_cyc[d] = -1; done_cnt[d] = 0; rd_cnt[d] = 0; wr_cnt[d] = 0;
      first_rd[d] = -1; rdata[d] = 'x; rexc[d] = 'x; wdata[d] = 'x; waddr[d] = 'x;
    end
  endtask

  task automatic note(input int d, input int k, input logic done, input logic rd,
                      input logic wr, input logic [31:0] rd_data, input logic [1:0] e,
                      input logic [31:0] wd, input logic [31:0] ma);
    if (rd) begin
      rd_cnt[d]++;
      if (first_rd[d] < 0) first_rd[d] = k;
    end
    if (wr) begin
      wr_cnt[d]++;
      wdata[d] = wd;
      waddr[d] = ma;
    end
    if (done) begin
      done_cnt[d]++;
      done_cyc[d] = k;
      rdata[d] = rd_data;
      rexc[d] = e;
    end
  endtask

  task automatic sample_both(input int k);
    note(0, k, bus1.rsp_done, bus1.mem_rd, bus1.mem_wr, bus1.rsp_data, bus1.rsp_exc,
         bus1.mem_wdata, bus1.mem_addr);
    note(1, k, bus3.rsp_done, bus3.mem_rd, bus3.mem_wr, bus3.rsp_data, bus3.rsp_exc,
         bus3.mem_wdata, bus3.mem_addr);
  endtask

  task automatic set_mem(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk);
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // One request, accepted on the next edge (cycle 0); cycles 1..10 observed.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    clear_stats();
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      sample_both(k);
    end
  endtask

  task automatic chk_txn(input string tag, input int d, input int exp_done,
                         input logic [31:0] exp_data, input logic [1:0] exp_exc,
                         input int exp_rd, input int exp_wr);
    chk($sformatf("%s_done_cyc_L%0d", tag, lat(d)), done_cyc[d], exp_done);
    chk($sformatf("%s_done_cnt_L%0d", tag, lat(d)), done_cnt[d], 1);
    chk($sformatf("%s_data_L%0d", tag, lat(d)), rdata[d], exp_data);
    chk($sformatf("%s_exc_L%0d", tag, lat(d)), 32'(rexc[d]), 32'(exp_exc));
    chk($sformatf("%s_rd_cnt_L%0d", tag, lat(d)), rd_cnt[d], exp_rd);
    chk($sformatf("%s_wr_cnt_L%0d", tag, lat(d)), wr_cnt[d], exp_wr);
  endtask

  initial begin
    int d1 [2];
    int d2 [2];
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    pre_en = 1'b0; pre_idx = 4'h0; pre_val = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus1.req_ready), 32'h0);
    chk("rst_done", 32'(bus1.rsp_done | bus3.rsp_done), 32'h0);
    chk("rst_rd_wr", 32'({bus1.mem_rd, bus1.mem_wr, bus3.mem_rd, bus3.mem_wr}), 32'h0);
    chk("rst_mem_addr", bus3.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus3.mem_wdata, 32'h0);
    chk("rst_rsp_data", bus1.rsp_data, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ready_after_rst", 32'({bus1.req_ready, bus3.req_ready}), 32'h3);

    // Byte load from lane 3
    set_mem(4'd0, 32'hA1B2C3D4);
    run_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    for (int d = 0; d < 2; d++) begin
      chk_txn("ld_b3", d, lat(d) + 1, 32'h000000A1, 2'b00, lat(d), 0);
      chk($sformatf("ld_b3_first_rd_L%0d", lat(d)), first_rd[d], 1);
    end

    // Half store into upper half (read-modify-write)
    set_mem(4'd0, 32'h11223344);
    run_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000BEEF);
    chk("st_h2_mem_L1", mem1[0], 32'hBEEF3344);
    chk("st_h2_mem_L3", mem3[0], 32'hBEEF3344);
    for (int d = 0; d < 2; d++) begin
      chk_txn("st_h2", d, lat(d) + 2, 32'h0, 2'b00, lat(d), 1);
      chk($sformatf("st_h2_wdata_L%0d", lat(d)), wdata[d], 32'hBEEF3344);
      chk($sformatf("st_h2_waddr_L%0d", lat(d)), waddr[d], 32'h00000100);
    end

    // Byte store to lane 1, upper wdata bits must be ignored
    run_req(1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFFFF5A);
    for (int d = 0; d < 2; d++) begin
      chk_txn("st_b1", d, lat(d) + 2, 32'h0, 2'b00, lat(d), 1);
      chk($sformatf("st_b1_wdata_L%0d", lat(d)), wdata[d], 32'hBEEF5A44);
    end

    // Word store, no read
    run_req(1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFEF00D);
    for (int d = 0; d < 2; d++) begin
      chk_txn("st_w", d, 2, 32'h0, 2'b00, 0, 1);
      chk($sformatf("st_w_wdata_L%0d", lat(d)), wdata[d], 32'hCAFEF00D);
      chk($sformatf("st_w_waddr_L%0d", lat(d)), waddr[d], 32'h00000104);
    end

    // Word and upper-half loads of the stored word
    run_req(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    for (int d = 0; d < 2; d++) chk_txn("ld_w", d, lat(d) + 1, 32'hCAFEF00D, 2'b00, lat(d), 0);
    run_req(1'b0, 2'b01, 1'b1, 32'h106, 32'h0);
    for (int d = 0; d < 2; d++)
      chk_txn("ld_h2", d, lat(d) + 1, SE ? 32'hFFFFCAFE : 32'h0000CAFE, 2'b00, lat(d), 0);

    // Faults
    run_req(1'b1, 2'b10, 1'b0, 32'h101, 32'h12345678);
    for (int d = 0; d < 2; d++) chk_txn("flt_st_w", d, 1, 32'h0, 2'b10, 0, 0);
    run_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
    for (int d = 0; d < 2; d++) chk_txn("flt_ld_h", d, 1, 32'h0, 2'b01, 0, 0);
    run_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    for (int d = 0; d < 2; d++) chk_txn("flt_sz", d, 1, 32'h0, 2'b11, 0, 0);
    run_req(1'b1, 2'b11, 1'b0, 32'h104, 32'h0);
    for (int d = 0; d < 2; d++) chk_txn("flt_sz_st", d, 1, 32'h0, 2'b11, 0, 0);
    chk("flt_mem_kept", mem1[0], 32'hBEEF5A44);

    // Extension behaviour
    set_mem(4'd2, 32'h80017F80);
    run_req(1'b0, 2'b00, 1'b1, 32'h108, 32'h0);
    for (int d = 0; d < 2; d++)
      chk_txn("ld_sb0", d, lat(d) + 1, SE ? 32'hFFFFFF80 : 32'h00000080, 2'b00, lat(d), 0);
    run_req(1'b0, 2'b00, 1'b0, 32'h108, 32'h0);
    for (int d = 0; d < 2; d++) chk_txn("ld_ub0", d, lat(d) + 1, 32'h00000080, 2'b00, lat(d), 0);
    run_req(1'b0, 2'b00, 1'b1, 32'h109, 32'h0);
    for (int d = 0; d < 2; d++) chk_txn("ld_sb1", d, lat(d) + 1, 32'h0000007F, 2'b00, lat(d), 0);
    run_req(1'b0, 2'b01, 1'b1, 32'h10A, 32'h0);
    for (int d = 0; d < 2; d++)
      chk_txn("ld_sh2", d, lat(d) + 1, SE ? 32'hFFFF8001 : 32'h00008001, 2'b00, lat(d), 0);

    // Reset in the middle of a byte store read phase
    clear_stats();
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h100;
    req_wdata = 32'h00000077; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_ready", 32'({bus1.req_ready, bus3.req_ready}), 32'h0);
    chk("rst_mid_outs", 32'({bus1.mem_rd, bus1.mem_wr, bus1.rsp_done,
                             bus3.mem_rd, bus3.mem_wr, bus3.rsp_done}), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_ready_rel", 32'({bus1.req_ready, bus3.req_ready}), 32'h3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      sample_both(k);
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_mid_wr_L%0d", lat(d)), wr_cnt[d], 0);
      chk($sformatf("rst_mid_done_L%0d", lat(d)), done_cnt[d], 0);
    end
    chk("rst_mid_mem_L1", mem1[0], 32'hBEEF5A44);
    chk("rst_mid_mem_L3", mem3[0], 32'hBEEF5A44);

    // req_valid held across two word loads
    for (int d = 0; d < 2; d++) begin d1[d] = -1; d2[d] = -1; end
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h104;
    req_wdata = 32'h0; req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus1.rsp_done) begin
        if (d1[0] < 0) d1[0] = k; else if (d2[0] < 0) d2[0] = k;
      end
      if (bus3.rsp_done) begin
        if (d1[1] < 0) d1[1] = k; else if (d2[1] < 0) d2[1] = k;
      end
    end
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("b2b_first_L%0d", lat(d)), d1[d], lat(d) + 1);
      chk($sformatf("b2b_second_L%0d", lat(d)), d2[d], 2 * lat(d) + 3);
      chk($sformatf("b2b_gap_L%0d", lat(d)), d2[d] - d1[d], lat(d) + 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
